// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/instr_loader_packer.sv
// Assembles accepted bytes into little-endian 32-bit words; pulses word_valid_o
// combinationally on the fourth byte of each group.
module instr_loader_packer (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        byte_fire_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Newest byte enters at the top, so byte 0 of a group ends up in bits [7:0].
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (byte_fire_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_data_i, shift_q[23:8]};
    end
  end

  assign word_o       = {byte_data_i, shift_q};
  assign word_valid_o = byte_fire_i && (cnt_q == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Framed boot loader: length header, payload words written to ROM, checksum
// trailer; the core is released from reset only after a verified frame.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int MEM_SIZE = 16384,
  parameter int ADDR_W   = 32
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_no,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam int MAX_WORDS = MEM_SIZE / BYTES_PER_WORD;
  localparam int IDX_W     = $clog2(MAX_WORDS) + 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [31:0]        sum_q, sum_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               byte_fire;
  logic               word_valid;
  logic [31:0]        word;

  assign byte_fire = byte_valid_i && byte_ready_o;

  instr_loader_packer u_packer (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .byte_fire_i  (byte_fire),
    .byte_data_i  (byte_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q    <= ST_LEN;
      len_q      <= '0;
      word_idx_q <= '0;
      sum_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      sum_q      <= sum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Every decision is taken on the fourth byte of a group; the write port
  // registers are loaded at the same moment so the strobe follows one cycle later.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    sum_d      = sum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_LEN: begin
        if (word_valid) begin
          len_d = word[IDX_W-1:0];
          if (word > 32'(MAX_WORDS)) state_d = ST_ERR;
          else if (word == 32'd0)    state_d = ST_CSUM;
          else                       state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          we_d       = 1'b1;
          addr_d     = ADDR_W'({word_idx_q, 2'b00});
          wdata_d    = word;
          sum_d      = sum_q + word;
          word_idx_d = word_idx_q + IDX_W'(1);
          if (word_idx_d == len_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (word_valid) state_d = (word == sum_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_comb begin
    byte_ready_o = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    core_rst_no  = (state_q == ST_DONE);
    load_done_o  = (state_q == ST_DONE);
    load_err_o   = (state_q == ST_ERR);
    mem_we_o     = we_q;
    mem_be_o     = we_q ? BE_FULL : 4'b0000;
    mem_addr_o   = addr_q;
    mem_wdata_o  = wdata_q;
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a table of whole frames plus hand-written
// sequences for write timing, the size limit and reset in the middle of a frame.
module tb_instr_loader;

  logic        clk_sys;
  logic        rst_sys_n;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        core_rst_no;
  logic        load_done_o;
  logic        load_err_o;

  instr_loader #(.MEM_SIZE(16384), .ADDR_W(32)) dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_rst_no  (core_rst_no),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [31:0]       n;
    logic [3:0][31:0]  w;
    logic [31:0]       csum;
    bit                gaps;
    bit                exp_done;
    bit                exp_err;
    int                exp_writes;
  } vec_t;

  int          vec_count = 0;
  int          fail_count = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  bit          stream_ok;
  bit          prev_we = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Capture every ROM write and check strobe shape away from the clock edge.
  always @(negedge clk_sys) begin
    if (rst_sys_n && mem_we_o) begin
      wr_addr.push_back(mem_addr_o);
      wr_data.push_back(mem_wdata_o);
      check_output("write_be", 32'(mem_be_o), 32'hF);
      check_output("write_single_cycle", 32'(prev_we), 32'd0);
    end
    prev_we = mem_we_o;
  end

  task automatic reset_dut();
    rst_sys_n    = 1'b0;
    byte_valid_i = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_output("rst_ready", 32'(byte_ready_o), 32'd1);
    check_output("rst_we", 32'(mem_we_o), 32'd0);
    check_output("rst_be", 32'(mem_be_o), 32'd0);
    check_output("rst_addr", mem_addr_o, 32'd0);
    check_output("rst_wdata", mem_wdata_o, 32'd0);
    check_output("rst_core_rst_n", 32'(core_rst_no), 32'd0);
    check_output("rst_done", 32'(load_done_o), 32'd0);
    check_output("rst_err", 32'(load_err_o), 32'd0);
    wr_addr.delete();
    wr_data.delete();
    rst_sys_n = 1'b1;
    stream_ok = 1'b1;
  endtask

  // Presents one byte at a negedge; it is taken on the next posedge if ready.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid_i = 1'b0;
        byte_data_i  = 8'($urandom);
        @(negedge clk_sys);
      end
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    stream_ok    = byte_ready_o;
    @(negedge clk_sys);
    byte_valid_i = 1'b0;
    byte_data_i  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int b = 0; b < 4; b++) begin
      if (stream_ok) send_byte(w[8*b +: 8], gaps);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    int nw;
    nw = (v.n > 32'd4) ? 4 : int'(v.n);
    send_word(v.n, v.gaps);
    for (int i = 0; i < nw; i++) send_word(v.w[i], v.gaps);
    send_word(v.csum, v.gaps);
  endtask

  vec_t vecs[7];

  initial begin
    int nwr;
    rst_sys_n    = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;

    vecs[0] = '{32'd2, {32'h0, 32'h0, 32'hDEADBEEF, 32'h12345678}, 32'hF0E21567, 1'b0, 1'b1, 1'b0, 2};
    vecs[1] = '{32'd2, {32'h0, 32'h0, 32'hDEADBEEF, 32'h12345678}, 32'hF1F4F2F0, 1'b0, 1'b0, 1'b1, 2};
    vecs[2] = '{32'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 32'h00000000, 1'b0, 1'b1, 1'b0, 0};
    vecs[3] = '{32'd1, {32'h0, 32'h0, 32'h0, 32'h00000001}, 32'h00000002, 1'b0, 1'b0, 1'b1, 1};
    vecs[4] = '{32'd4097, {32'h4, 32'h3, 32'h2, 32'h1}, 32'h0000000A, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{32'd4, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, 4};
    vecs[6] = '{32'd4, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 32'hAAAAAAAA, 1'b1, 1'b1, 1'b0, 4};

    @(negedge clk_sys);

    // Whole-frame vectors: final status plus the captured write sequence.
    for (int i = 0; i < 7; i++) begin
      reset_dut();
      apply_stimulus(vecs[i]);
      @(negedge clk_sys);
      check_output($sformatf("v%0d_done", i), 32'(load_done_o), 32'(vecs[i].exp_done));
      check_output($sformatf("v%0d_err", i), 32'(load_err_o), 32'(vecs[i].exp_err));
      check_output($sformatf("v%0d_core_rst_n", i), 32'(core_rst_no), 32'(vecs[i].exp_done));
      check_output($sformatf("v%0d_ready", i), 32'(byte_ready_o), 32'd0);
      check_output($sformatf("v%0d_nwrites", i), 32'(wr_addr.size()), 32'(vecs[i].exp_writes));
      nwr = (wr_addr.size() < vecs[i].exp_writes) ? wr_addr.size() : vecs[i].exp_writes;
      for (int k = 0; k < nwr; k++) begin
        check_output($sformatf("v%0d_addr%0d", i, k), wr_addr[k], 32'(4 * k));
        check_output($sformatf("v%0d_data%0d", i, k), wr_data[k], vecs[i].w[k]);
      end
      send_byte(8'hA5, 1'b0);
      @(negedge clk_sys);
      check_output($sformatf("v%0d_ignored_byte", i), 32'(wr_addr.size()), 32'(vecs[i].exp_writes));
      check_output($sformatf("v%0d_done_hold", i), 32'(load_done_o), 32'(vecs[i].exp_done));
    end

    // Cycle-level timing of writes and of the DONE transition.
    reset_dut();
    send_word(32'd2, 1'b0);
    check_output("t_state_data_core_rst_n", 32'(core_rst_no), 32'd0);
    send_byte(8'h78, 1'b0); send_byte(8'h56, 1'b0); send_byte(8'h34, 1'b0);
    check_output("t_no_early_we", 32'(mem_we_o), 32'd0);
    send_byte(8'h12, 1'b0);
    check_output("t_we0", 32'(mem_we_o), 32'd1);
    check_output("t_addr0", mem_addr_o, 32'h0);
    check_output("t_wdata0", mem_wdata_o, 32'h12345678);
    @(negedge clk_sys);
    check_output("t_we0_drop", 32'(mem_we_o), 32'd0);
    check_output("t_be0_drop", 32'(mem_be_o), 32'd0);
    check_output("t_wdata_hold", mem_wdata_o, 32'h12345678);
    send_word(32'hDEADBEEF, 1'b0);
    check_output("t_we1", 32'(mem_we_o), 32'd1);
    check_output("t_addr1", mem_addr_o, 32'h4);
    check_output("t_wdata1", mem_wdata_o, 32'hDEADBEEF);
    send_byte(8'h67, 1'b0); send_byte(8'h15, 1'b0); send_byte(8'hE2, 1'b0);
    check_output("t_not_done_early", 32'(load_done_o), 32'd0);
    send_byte(8'hF0, 1'b0);
    check_output("t_done_next_cycle", 32'(load_done_o), 32'd1);
    check_output("t_core_released", 32'(core_rst_no), 32'd1);

    // N=0: DONE the cycle after the last checksum byte.
    reset_dut();
    send_word(32'd0, 1'b0);
    send_word(32'd0, 1'b0);
    check_output("n0_done_timing", 32'(load_done_o), 32'd1);

    // Size limit: exactly MEM_SIZE/4 words is accepted and fills the ROM.
    reset_dut();
    send_word(32'd4096, 1'b0);
    check_output("max_not_err", 32'(load_err_o), 32'd0);
    for (int i = 0; i < 4096; i++) send_word(32'(i), 1'b0);
    send_word(32'h007FF800, 1'b0);
    @(negedge clk_sys);
    check_output("max_done", 32'(load_done_o), 32'd1);
    check_output("max_nwrites", 32'(wr_addr.size()), 32'd4096);
    if (wr_addr.size() == 4096) begin
      check_output("max_last_addr", wr_addr[4095], 32'h3FFC);
      check_output("max_last_data", wr_data[4095], 32'hFFF);
    end

    // One word over the limit errors right after the header.
    reset_dut();
    send_word(32'd4097, 1'b0);
    check_output("over_err_timing", 32'(load_err_o), 32'd1);

    // Reset in the middle of a frame, then a fresh frame loads cleanly.
    reset_dut();
    send_word(32'd3, 1'b0);
    send_word(32'h0A0B0C0D, 1'b0);
    send_byte(8'h99, 1'b0);
    reset_dut();
    send_word(32'd1, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    @(negedge clk_sys);
    check_output("midrst_done", 32'(load_done_o), 32'd1);
    check_output("midrst_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check_output("midrst_addr", wr_addr[0], 32'h0);
      check_output("midrst_data", wr_data[0], 32'hCAFEF00D);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
